mem_sram_responder: RTL and testbench
=====================================

Name: mem_sram_responder

Overview:
- Responder end of the native 32-bit CPU memory bus (mem_valid/mem_instr/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Decodes a configurable address window and holds a single-port word RAM with byte write strobes.
- Adds a programmable number of wait states and answers with a one-cycle mem_ready pulse.
- Sits behind the CPU bus wrapper as on-chip RAM; requests outside its window are left unanswered so that other responders can take them.

Parameters:
ADDR_BASE, 32'h0001_0000, base byte address of window; must be aligned to 2^(ADDR_BITS+2)
ADDR_BITS, 10, log2 of RAM depth in 32-bit words (default 4 KB, 0x10000-0x10FFF)
WAIT_STATES, 1, extra cycles inserted before mem_ready (legal range 0..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
mem_valid  input  1  request present; initiator holds it and all request fields until mem_ready
mem_instr  input  1  instruction fetch flag; informational, no effect on behaviour
mem_addr  input  32  byte address; bits [1:0] ignored
mem_wdata  input  32  write data
mem_wstrb  input  4  byte enables; 0 = read, nonzero = write of enabled bytes
mem_ready  output  1  one-cycle completion pulse for a hit request
mem_rdata  output  32  read data, valid only while mem_ready=1, otherwise 0
busy  output  1  high from acceptance until the mem_ready cycle inclusive

Behaviour:
- Reset (async assert, sync release): state IDLE, mem_ready=0, mem_rdata=0, busy=0, wait counter=0. RAM contents are not reset.
- hit = mem_valid & (mem_addr[31:ADDR_BITS+2] == ADDR_BASE[31:ADDR_BITS+2]). Word index = mem_addr[ADDR_BITS+1:2].
- States: IDLE, WAIT, RESP.
- IDLE:
  - If hit in cycle N: capture word index, wdata and wstrb.
  - Load counter = WAIT_STATES; busy=1 from N+1.
  - Go to RESP if WAIT_STATES==0, else go to WAIT.
  - A non-hit leaves the block in IDLE with all outputs 0.
- WAIT: decrement counter each cycle; go to RESP when it reaches 1. In all cases mem_ready rises in cycle N+1+WAIT_STATES.
- RESP:
  - mem_ready=1 for exactly one cycle.
  - Read: mem_rdata = RAM word at the captured index. This includes any write that completed earlier, even the immediately preceding one.
  - Write: mem_rdata=0. Enabled bytes are updated on the clock edge that ends the RESP cycle; disabled bytes are unchanged.
  - Next state is IDLE unconditionally. busy=0 and mem_ready=0 in the following cycle.
- Back-to-back:
  - mem_valid high in the cycle after mem_ready is a new request.
  - It is evaluated in IDLE, so the minimum spacing is 2+WAIT_STATES cycles per access.
- Request fields changing during WAIT/RESP are ignored; the captured values are used.
- mem_valid dropping before mem_ready (protocol violation): abort to IDLE next cycle, no mem_ready, no RAM write.
- Reset asserted mid-transaction: immediate return to IDLE, no mem_ready, no RAM write.
- mem_instr=1 with nonzero wstrb is treated as a normal write.
- Address wrap: only the window compare and index bits are used. No carry or overflow handling is needed.

Test Plan:
- WAIT_STATES=1: write 0xDEADBEEF, wstrb=4'hF to 0x10010 with valid in cycle 0 -> mem_ready=1 only in cycle 2, mem_rdata=0. Then read 0x10010 -> mem_rdata=0xDEADBEEF in its ready cycle.
- Byte strobes: word 0x10020 preloaded with 0x11223344; write 0xAABBCCDD, wstrb=4'b0101 -> subsequent read returns 0x11BB33DD.
- Out of window: read 0x00000010 and 0x11000 held for 10 cycles -> mem_ready stays 0, busy stays 0, mem_rdata=0.
- Back-to-back, WAIT_STATES=0: write 0x5 to 0x10FFC, then read 0x10FFC with valid held continuously -> ready pulses in cycles 1 and 3, read data 0x00000005. Also confirms the top word and index wrap are correct.
- Abort/reset: start a write of 0x12345678 to 0x10040 (WAIT_STATES=3).
  - Drop mem_valid in cycle 2 -> no ready; a later read returns the old value.
  - Repeat, asserting reset in cycle 2 -> outputs 0 immediately, no write.
- Field stability: change mem_addr to 0x10044 during WAIT -> access still goes to 0x10040.

Source files
------------

// File: rtl/mem_sram_responder_if.sv
// Native 32-bit CPU memory bus: request fields from the initiator, ready/rdata from the responder.
// Latency: none (wires only).
// Backpressure: the initiator holds mem_valid and all request fields until mem_ready.
interface mem_sram_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_sram_responder.sv
// On-chip word RAM answering the native CPU memory bus inside an address window.
// Latency: mem_ready pulses WAIT_STATES+1 cycles after a hit is accepted.
// Backpressure: one access at a time; out-of-window requests are left unanswered.
// Ports: clk, reset (async active-high), bus (slave: request in, ready/rdata out), busy.
module mem_sram_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_sram_responder_if.slave  bus,
    output logic                 busy
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WS4   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic                   capture;
    logic                   hit;
    logic                   resp_ok;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            wdata_q;
    logic [3:0]             wstrb_q;
    logic [31:0]            ram [DEPTH];

    // mem_instr is informational only and the byte offset is irrelevant for a word RAM.
    logic unused_inputs;
    assign unused_inputs = ^{bus.mem_instr, bus.mem_addr[1:0]};

    assign hit = bus.mem_valid &&
                 (bus.mem_addr[31:ADDR_BITS+2] == ADDR_BASE[31:ADDR_BITS+2]);

    // An initiator that drops mem_valid in the response cycle gets neither a
    // pulse nor a RAM update.
    assign resp_ok = (state == RESP) && bus.mem_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                idx_q   <= bus.mem_addr[ADDR_BITS+1:2];
                wdata_q <= bus.mem_wdata;
                wstrb_q <= bus.mem_wstrb;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    capture   = 1'b1;
                    cnt_nxt   = WS4;
                    state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!bus.mem_valid) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    // Leaving on cnt==1 puts RESP exactly WAIT_STATES cycles after acceptance.
                    if (cnt <= 4'd1) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write lands on the edge closing RESP, so a following read already sees it.
    always_ff @(posedge clk) begin
        if (resp_ok && (wstrb_q != 4'd0)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    ram[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_ready = resp_ok;
    assign bus.mem_rdata = (resp_ok && (wstrb_q == 4'd0)) ? ram[idx_q] : 32'd0;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_sram_responder.sv
module tb_mem_sram_responder;

    logic clk;
    logic reset;
    logic busy0, busy1, busy3;
    int   tests_run;
    int   fails;

    mem_sram_responder_if if0 ();
    mem_sram_responder_if if1 ();
    mem_sram_responder_if if3 ();

    mem_sram_responder #(.ADDR_BASE(32'h0001_0000), .ADDR_BITS(10), .WAIT_STATES(0))
        u_ws0 (.clk(clk), .reset(reset), .bus(if0), .busy(busy0));
    mem_sram_responder #(.ADDR_BASE(32'h0001_0000), .ADDR_BITS(10), .WAIT_STATES(1))
        u_ws1 (.clk(clk), .reset(reset), .bus(if1), .busy(busy1));
    mem_sram_responder #(.ADDR_BASE(32'h0001_0000), .ADDR_BITS(10), .WAIT_STATES(3))
        u_ws3 (.clk(clk), .reset(reset), .bus(if3), .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inst: 0 -> WAIT_STATES=0, 1 -> WAIT_STATES=1, 2 -> WAIT_STATES=3
    task automatic drive(input int inst, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        case (inst)
            0: begin if0.mem_valid = v; if0.mem_instr = 1'b0; if0.mem_addr = a; if0.mem_wdata = d; if0.mem_wstrb = s; end
            1: begin if1.mem_valid = v; if1.mem_instr = 1'b0; if1.mem_addr = a; if1.mem_wdata = d; if1.mem_wstrb = s; end
            default: begin if3.mem_valid = v; if3.mem_instr = 1'b0; if3.mem_addr = a; if3.mem_wdata = d; if3.mem_wstrb = s; end
        endcase
    endtask

    task automatic sample(input int inst, output logic r, output logic [31:0] rd, output logic b);
        case (inst)
            0: begin r = if0.mem_ready; rd = if0.mem_rdata; b = busy0; end
            1: begin r = if1.mem_ready; rd = if1.mem_rdata; b = busy1; end
            default: begin r = if3.mem_ready; rd = if3.mem_rdata; b = busy3; end
        endcase
    endtask

    // Starts just after a rising edge (cycle 0 = first cycle with mem_valid high).
    // Returns the cycle of the first ready pulse (-1 if none within 8 cycles),
    // the number of pulses, the data seen with the first pulse and a busy mask.
    task automatic acc(input int inst, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int rc, output int rn,
                       output logic [31:0] rd, output logic [7:0] bm);
        logic        r, b;
        logic [31:0] rdv;
        drive(inst, 1'b1, a, d, s);
        rc = -1; rn = 0; rd = 32'd0; bm = 8'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sample(inst, r, rdv, b);
            bm[c] = b;
            if (r === 1'b1) begin
                if (rn == 0) begin rc = c; rd = rdv; end
                rn++;
            end
            @(posedge clk); #1;
            if (rn > 0) drive(inst, 1'b0, 32'd0, 32'd0, 4'd0);
        end
        drive(inst, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic test_reset;
        logic r, b;
        logic [31:0] rd;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sample(i, r, rd, b);
            tests_run++;
            if ({r, b, rd} !== 34'd0) begin
                fails++;
                $display("FAIL reset_outputs inst%0d: got ready=%b busy=%b rdata=%h, expected all 0", i, r, b, rd);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write_read;
        int rc, rn;
        logic [31:0] rd;
        logic [7:0] bm;
        acc(1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, rc, rn, rd, bm);
        tests_run++;
        if (rc !== 2 || rn !== 1) begin
            fails++;
            $display("FAIL wr_ready_cycle: got cycle=%0d pulses=%0d, expected cycle=2 pulses=1", rc, rn);
        end
        tests_run++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL wr_rdata: got %h, expected 00000000", rd);
        end
        tests_run++;
        if (bm !== 8'b0000_0110) begin
            fails++;
            $display("FAIL wr_busy_mask: got %b, expected 00000110", bm);
        end
        acc(1, 32'h0001_0010, 32'd0, 4'h0, rc, rn, rd, bm);
        tests_run++;
        if (rc !== 2 || rd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL rd_after_wr: got cycle=%0d data=%h, expected cycle=2 data=deadbeef", rc, rd);
        end
    endtask

    task automatic test_byte_strobes;
        int rc, rn;
        logic [31:0] rd;
        logic [7:0] bm;
        acc(1, 32'h0001_0020, 32'h1122_3344, 4'hF, rc, rn, rd, bm);
        acc(1, 32'h0001_0020, 32'hAABB_CCDD, 4'b0101, rc, rn, rd, bm);
        acc(1, 32'h0001_0020, 32'd0, 4'h0, rc, rn, rd, bm);
        tests_run++;
        if (rd !== 32'h11BB_33DD) begin
            fails++;
            $display("FAIL byte_strobe: got %h, expected 11bb33dd", rd);
        end
    endtask

    task automatic test_out_of_window;
        logic r, b;
        logic [31:0] rd;
        logic [31:0] addrs [2];
        int bad;
        addrs[0] = 32'h0000_0010;
        addrs[1] = 32'h0001_1000;
        for (int k = 0; k < 2; k++) begin
            drive(1, 1'b1, addrs[k], 32'd0, 4'h0);
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                sample(1, r, rd, b);
                if ({r, b, rd} !== 34'd0) bad++;
                @(posedge clk); #1;
            end
            tests_run++;
            if (bad !== 0) begin
                fails++;
                $display("FAIL out_of_window addr=%h: got %0d active cycles, expected 0", addrs[k], bad);
            end
        end
        drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic test_back_to_back;
        int rc, rn;
        logic [31:0] rd, rd1, rd3, rdv;
        logic [7:0] bm, rmask;
        logic r, b;
        acc(0, 32'h0001_0000, 32'hA5A5_A5A5, 4'hF, rc, rn, rd, bm);
        tests_run++;
        if (rc !== 1 || bm !== 8'b0000_0010) begin
            fails++;
            $display("FAIL ws0_latency: got cycle=%0d busy=%b, expected cycle=1 busy=00000010", rc, bm);
        end
        drive(0, 1'b1, 32'h0001_0FFC, 32'h0000_0005, 4'hF);
        rmask = 8'd0; rd1 = 32'hFFFF_FFFF; rd3 = 32'hFFFF_FFFF;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            sample(0, r, rdv, b);
            rmask[c] = (r === 1'b1);
            if (c == 1) rd1 = rdv;
            if (c == 3) rd3 = rdv;
            @(posedge clk); #1;
            if (c == 1) drive(0, 1'b1, 32'h0001_0FFC, 32'd0, 4'h0);
            if (c == 3) drive(0, 1'b0, 32'd0, 32'd0, 4'h0);
        end
        tests_run++;
        if (rmask !== 8'b0000_1010) begin
            fails++;
            $display("FAIL b2b_ready_cycles: got %b, expected 00001010", rmask);
        end
        tests_run++;
        if (rd1 !== 32'd0 || rd3 !== 32'h0000_0005) begin
            fails++;
            $display("FAIL b2b_rdata: got wr=%h rd=%h, expected wr=00000000 rd=00000005", rd1, rd3);
        end
        acc(0, 32'h0001_0000, 32'd0, 4'h0, rc, rn, rd, bm);
        tests_run++;
        if (rd !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL index_wrap: got %h, expected a5a5a5a5", rd);
        end
    endtask

    task automatic test_abort;
        int rc, rn, hits;
        logic [31:0] rd, rdv;
        logic [7:0] bm;
        logic r, b;
        acc(2, 32'h0001_0040, 32'hCAFE_F00D, 4'hF, rc, rn, rd, bm);
        tests_run++;
        if (rc !== 4 || bm !== 8'b0001_1110) begin
            fails++;
            $display("FAIL ws3_latency: got cycle=%0d busy=%b, expected cycle=4 busy=00011110", rc, bm);
        end
        // valid dropped at the start of cycle 2
        drive(2, 1'b1, 32'h0001_0040, 32'h1234_5678, 4'hF);
        hits = 0; bm = 8'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sample(2, r, rdv, b);
            bm[c] = b;
            if (r === 1'b1) hits++;
            @(posedge clk); #1;
            if (c == 1) drive(2, 1'b0, 32'd0, 32'd0, 4'h0);
        end
        tests_run++;
        if (hits !== 0 || bm !== 8'b0000_0110) begin
            fails++;
            $display("FAIL abort_valid_drop: got pulses=%0d busy=%b, expected pulses=0 busy=00000110", hits, bm);
        end
        acc(2, 32'h0001_0040, 32'd0, 4'h0, rc, rn, rd, bm);
        tests_run++;
        if (rd !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL abort_no_write: got %h, expected cafef00d", rd);
        end
        // reset asserted at the start of cycle 2
        drive(2, 1'b1, 32'h0001_0040, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        sample(2, r, rdv, b);
        tests_run++;
        if ({r, b, rdv} !== 34'd0) begin
            fails++;
            $display("FAIL reset_mid_txn: got ready=%b busy=%b rdata=%h, expected all 0", r, b, rdv);
        end
        drive(2, 1'b0, 32'd0, 32'd0, 4'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        acc(2, 32'h0001_0040, 32'd0, 4'h0, rc, rn, rd, bm);
        tests_run++;
        if (rc !== 4 || rd !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL reset_no_write: got cycle=%0d data=%h, expected cycle=4 data=cafef00d", rc, rd);
        end
    endtask

    task automatic test_field_stability;
        int rc, rn, first;
        logic [31:0] rd, rdv;
        logic [7:0] bm;
        logic r, b;
        acc(2, 32'h0001_0044, 32'h4444_4444, 4'hF, rc, rn, rd, bm);
        drive(2, 1'b1, 32'h0001_0040, 32'h0BAD_C0DE, 4'hF);
        first = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sample(2, r, rdv, b);
            if (r === 1'b1 && first < 0) first = c;
            @(posedge clk); #1;
            if (c == 0 && first < 0) drive(2, 1'b1, 32'h0001_0044, 32'hFFFF_FFFF, 4'hF);
            if (first >= 0) drive(2, 1'b0, 32'd0, 32'd0, 4'h0);
        end
        tests_run++;
        if (first !== 4) begin
            fails++;
            $display("FAIL stable_ready_cycle: got %0d, expected 4", first);
        end
        acc(2, 32'h0001_0040, 32'd0, 4'h0, rc, rn, rd, bm);
        tests_run++;
        if (rd !== 32'h0BAD_C0DE) begin
            fails++;
            $display("FAIL stable_captured_addr: got %h, expected 0badc0de", rd);
        end
        acc(2, 32'h0001_0044, 32'd0, 4'h0, rc, rn, rd, bm);
        tests_run++;
        if (rd !== 32'h4444_4444) begin
            fails++;
            $display("FAIL stable_other_word: got %h, expected 44444444", rd);
        end
    endtask

    initial begin
        tests_run = 0;
        fails = 0;
        test_reset();
        test_write_read();
        test_byte_strobes();
        test_out_of_window();
        test_back_to_back();
        test_abort();
        test_field_stability();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
